// File: rtl/tank_plant_model.sv
// Behavioural tank plant: two spin-up pump FSMs feed a saturating level counter
// with constant drain, sticky over/underflow flags and registered level sensors.
module tank_plant_model #(
    parameter int unsigned LEVEL_W    = 8,
    parameter int unsigned CAPACITY   = 200,
    parameter int unsigned LOW_TH     = 60,
    parameter int unsigned HIGH_TH    = 180,
    parameter int unsigned FILL_RATE  = 3,
    parameter int unsigned DRAIN_RATE = 2,
    parameter int unsigned PUMP_DELAY = 2,
    parameter int unsigned INIT_LEVEL = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               B1,
    input  logic               B2,
    input  logic               drain_en,
    input  logic               fault_i_low,
    output logic               I,
    output logic               S,
    output logic [LEVEL_W-1:0] level,
    output logic [1:0]         pump_flow,
    output logic               overflow,
    output logic               underflow
);

    localparam int unsigned CNT_W = $clog2(PUMP_DELAY + 1);
    localparam int unsigned RAW_W = LEVEL_W + 2;

    typedef enum logic [1:0] {
        PUMP_OFF    = 2'd0,
        PUMP_SPINUP = 2'd1,
        PUMP_RUN    = 2'd2
    } pump_state_t;

    logic [1:0] cmd;
    assign cmd = {B2, B1};

    for (genvar k = 0; k < 2; k++) begin : g_pump
        pump_state_t      state;
        pump_state_t      state_next;
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] cnt_next;
        logic             flow;
        logic             flow_next;

        always_ff @(posedge clk) begin
            if (reset) begin
                state <= PUMP_OFF;
                cnt   <= '0;
                flow  <= 1'b0;
            end else begin
                state <= state_next;
                cnt   <= cnt_next;
                flow  <= flow_next;
            end
        end

        // Command must be held PUMP_DELAY consecutive cycles before flow starts.
        always_comb begin
            state_next = state;
            cnt_next   = cnt;
            case (state)
                PUMP_OFF: begin
                    if (cmd[k]) begin
                        cnt_next   = CNT_W'(1);
                        state_next = (PUMP_DELAY == 1) ? PUMP_RUN : PUMP_SPINUP;
                    end
                end
                PUMP_SPINUP: begin
                    if (!cmd[k]) begin
                        state_next = PUMP_OFF;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = CNT_W'(cnt + 1'b1);
                        if (CNT_W'(cnt + 1'b1) == CNT_W'(PUMP_DELAY)) begin
                            state_next = PUMP_RUN;
                        end
                    end
                end
                PUMP_RUN: begin
                    if (!cmd[k]) begin
                        state_next = PUMP_OFF;
                        cnt_next   = '0;
                    end
                end
                default: begin
                    state_next = PUMP_OFF;
                    cnt_next   = '0;
                end
            endcase
        end

        always_comb begin
            flow_next = (state_next == PUMP_RUN);
        end
    end

    assign pump_flow = {g_pump[1].flow, g_pump[0].flow};

    logic [RAW_W-1:0]        pop_c;
    logic signed [RAW_W-1:0] raw_c;

    // Fill and drain netted in one signed update; modular RAW_W arithmetic keeps sign.
    always_comb begin
        pop_c = RAW_W'(pump_flow[0]) + RAW_W'(pump_flow[1]);
        raw_c = signed'(RAW_W'(RAW_W'(level) + RAW_W'(FILL_RATE) * pop_c
                               - (drain_en ? RAW_W'(DRAIN_RATE) : RAW_W'(0))));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            level     <= LEVEL_W'(INIT_LEVEL);
            I         <= 1'b0;
            S         <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (raw_c[RAW_W-1]) begin
                level     <= '0;
                underflow <= 1'b1;
            end else if (raw_c > signed'(RAW_W'(CAPACITY))) begin
                level    <= LEVEL_W'(CAPACITY);
                overflow <= 1'b1;
            end else begin
                level <= LEVEL_W'(raw_c);
            end
            I <= (level >= LEVEL_W'(LOW_TH)) && !fault_i_low;
            S <= (level >= LEVEL_W'(HIGH_TH));
        end
    end

endmodule

// File: tb/tb_tank_plant_model.sv
// Bench for tank_plant_model: four instances differing only in INIT_LEVEL share
// stimulus; directed scenarios plus a randomized run against a behavioural model.
module tb_tank_plant_model;

    logic clk = 1'b0;
    logic reset, b1, b2, drain_en, fault;

    logic       s_i    [4];
    logic       s_s    [4];
    logic [7:0] s_lvl  [4];
    logic [1:0] s_flow [4];
    logic       s_ov   [4];
    logic       s_un   [4];

    int checks = 0;
    int errors = 0;

    // Behavioural model: level as plain integer, pumps as "cycles held" counts.
    int init_lvl [4] = '{0, 198, 1, 190};
    int m_lvl [4];
    int m_i [4], m_s [4], m_ov [4], m_un [4];
    int held [2];
    int m_flow [2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        tank_plant_model #(
            .INIT_LEVEL((g == 0) ? 0 : (g == 1) ? 198 : (g == 2) ? 1 : 190)
        ) u_dut (
            .clk(clk), .reset(reset), .B1(b1), .B2(b2), .drain_en(drain_en),
            .fault_i_low(fault), .I(s_i[g]), .S(s_s[g]), .level(s_lvl[g]),
            .pump_flow(s_flow[g]), .overflow(s_ov[g]), .underflow(s_un[g])
        );
    end

    task automatic step(input logic r, input logic p1, input logic p2,
                        input logic d, input logic f);
        int pop;
        int raw;
        int cmd [2];
        reset = r; b1 = p1; b2 = p2; drain_en = d; fault = f;
        cmd[0] = int'(p1);
        cmd[1] = int'(p2);
        @(posedge clk);
        if (r) begin
            for (int g = 0; g < 4; g++) begin
                m_lvl[g] = init_lvl[g];
                m_i[g] = 0; m_s[g] = 0; m_ov[g] = 0; m_un[g] = 0;
            end
            held[0] = 0; held[1] = 0; m_flow[0] = 0; m_flow[1] = 0;
        end else begin
            pop = m_flow[0] + m_flow[1];
            for (int g = 0; g < 4; g++) begin
                m_i[g] = (m_lvl[g] >= 60 && !f) ? 1 : 0;
                m_s[g] = (m_lvl[g] >= 180) ? 1 : 0;
                raw = m_lvl[g] + 3 * pop - (d ? 2 : 0);
                if (raw > 200) begin m_lvl[g] = 200; m_ov[g] = 1; end
                else if (raw < 0) begin m_lvl[g] = 0; m_un[g] = 1; end
                else m_lvl[g] = raw;
            end
            for (int k = 0; k < 2; k++) begin
                held[k] = cmd[k] ? ((held[k] < 100) ? held[k] + 1 : held[k]) : 0;
                m_flow[k] = (held[k] >= 2) ? 1 : 0;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        step(1, 0, 0, 0, 0);
        for (int n = 0; n < 10; n++) step(0, 0, 0, 0, 0);
        checks++;
        if (s_lvl[0] !== 8'd0 || s_i[0] !== 1'b0 || s_s[0] !== 1'b0 || s_flow[0] !== 2'b00
            || s_ov[0] !== 1'b0 || s_un[0] !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got lvl=%0d I=%b S=%b flow=%b ov=%b un=%b, want 0 0 0 00 0 0",
                     s_lvl[0], s_i[0], s_s[0], s_flow[0], s_ov[0], s_un[0]);
        end
    endtask

    task automatic test_fill();
        int exp_lvl;
        step(1, 0, 0, 0, 0);
        for (int n = 1; n <= 63; n++) begin
            step(0, 1, 0, 0, 0);
            exp_lvl = (n >= 2) ? 3 * (n - 2) : 0;
            checks++;
            if (s_lvl[0] !== 8'(exp_lvl) || s_flow[0] !== ((n >= 2) ? 2'b01 : 2'b00)
                || s_i[0] !== (n >= 23) || s_s[0] !== (n >= 63)) begin
                errors++;
                $display("FAIL fill_edge%0d: got lvl=%0d flow=%b I=%b S=%b, want lvl=%0d flow=%b I=%b S=%b",
                         n, s_lvl[0], s_flow[0], s_i[0], s_s[0], exp_lvl,
                         (n >= 2) ? 2'b01 : 2'b00, n >= 23, n >= 63);
            end
        end
    endtask

    task automatic test_pulse();
        step(1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        for (int n = 0; n < 5; n++) begin
            step(0, 0, 0, 0, 0);
            checks++;
            if (s_lvl[0] !== 8'd0 || s_flow[0] !== 2'b00) begin
                errors++;
                $display("FAIL pulse_cycle%0d: got lvl=%0d flow=%b, want 0 00", n, s_lvl[0], s_flow[0]);
            end
        end
    endtask

    task automatic test_overflow();
        step(1, 0, 0, 0, 0);
        step(0, 1, 1, 0, 0);
        step(0, 1, 1, 0, 0);
        checks++;
        if (s_flow[1] !== 2'b11 || s_lvl[1] !== 8'd198) begin
            errors++;
            $display("FAIL ovf_run: got flow=%b lvl=%0d, want 11 198", s_flow[1], s_lvl[1]);
        end
        step(0, 1, 1, 1, 0);
        checks++;
        if (s_lvl[1] !== 8'd200 || s_ov[1] !== 1'b1 || s_un[1] !== 1'b0) begin
            errors++;
            $display("FAIL ovf_sat: got lvl=%0d ov=%b un=%b, want 200 1 0", s_lvl[1], s_ov[1], s_un[1]);
        end
        for (int n = 0; n < 4; n++) step(0, 0, 0, 1, 0);
        checks++;
        if (s_ov[1] !== 1'b1 || s_flow[1] !== 2'b00) begin
            errors++;
            $display("FAIL ovf_sticky: got ov=%b flow=%b, want 1 00", s_ov[1], s_flow[1]);
        end
    endtask

    task automatic test_underflow();
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        checks++;
        if (s_lvl[2] !== 8'd0 || s_un[2] !== 1'b1 || s_i[2] !== 1'b0 || s_s[2] !== 1'b0
            || s_ov[2] !== 1'b0) begin
            errors++;
            $display("FAIL underflow: got lvl=%0d un=%b I=%b S=%b ov=%b, want 0 1 0 0 0",
                     s_lvl[2], s_un[2], s_i[2], s_s[2], s_ov[2]);
        end
    endtask

    task automatic test_fault_and_reset();
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        checks++;
        if (s_i[3] !== 1'b1 || s_s[3] !== 1'b1 || s_lvl[3] !== 8'd190) begin
            errors++;
            $display("FAIL sensors_high: got I=%b S=%b lvl=%0d, want 1 1 190", s_i[3], s_s[3], s_lvl[3]);
        end
        step(0, 0, 0, 0, 1);
        checks++;
        if (s_i[3] !== 1'b0 || s_s[3] !== 1'b1 || s_lvl[3] !== 8'd190) begin
            errors++;
            $display("FAIL fault_i_low: got I=%b S=%b lvl=%0d, want 0 1 190", s_i[3], s_s[3], s_lvl[3]);
        end
        for (int n = 0; n < 4; n++) step(0, 1, 1, 0, 0);
        checks++;
        if (s_flow[3] !== 2'b11 || s_ov[3] !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_run: got flow=%b ov=%b, want 11 1", s_flow[3], s_ov[3]);
        end
        step(1, 1, 1, 1, 1);
        checks++;
        if (s_lvl[3] !== 8'd190 || s_i[3] !== 1'b0 || s_s[3] !== 1'b0 || s_flow[3] !== 2'b00
            || s_ov[3] !== 1'b0 || s_un[3] !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: got lvl=%0d I=%b S=%b flow=%b ov=%b un=%b, want 190 0 0 00 0 0",
                     s_lvl[3], s_i[3], s_s[3], s_flow[3], s_ov[3], s_un[3]);
        end
        // spin-up progress must restart after reset
        step(0, 1, 1, 0, 0);
        checks++;
        if (s_flow[3] !== 2'b00) begin
            errors++;
            $display("FAIL spinup_restart: got flow=%b, want 00", s_flow[3]);
        end
    endtask

    task automatic test_random();
        logic r, p1, p2, d, f;
        logic [1:0] ef;
        step(1, 0, 0, 0, 0);
        for (int n = 0; n < 600; n++) begin
            r  = ($urandom_range(0, 59) == 0);
            p1 = ($urandom_range(0, 3) != 0);
            p2 = ($urandom_range(0, 2) == 0);
            d  = ($urandom_range(0, 1) == 1);
            f  = ($urandom_range(0, 7) == 0);
            step(r, p1, p2, d, f);
            ef = {1'(m_flow[1]), 1'(m_flow[0])};
            for (int g = 0; g < 4; g++) begin
                checks++;
                if (s_lvl[g] !== 8'(m_lvl[g]) || s_i[g] !== 1'(m_i[g]) || s_s[g] !== 1'(m_s[g])
                    || s_flow[g] !== ef || s_ov[g] !== 1'(m_ov[g]) || s_un[g] !== 1'(m_un[g])) begin
                    errors++;
                    $display("FAIL random_c%0d_dut%0d: got lvl=%0d I=%b S=%b flow=%b ov=%b un=%b, want lvl=%0d I=%0d S=%0d flow=%b ov=%0d un=%0d",
                             n, g, s_lvl[g], s_i[g], s_s[g], s_flow[g], s_ov[g], s_un[g],
                             m_lvl[g], m_i[g], m_s[g], ef, m_ov[g], m_un[g]);
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1; b1 = 1'b0; b2 = 1'b0; drain_en = 1'b0; fault = 1'b0;
        test_reset();
        test_fill();
        test_pulse();
        test_overflow();
        test_underflow();
        test_fault_and_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
